// File: rtl/deltasigma_decoder.sv
// Sinc2 CIC decimator: turns a strobed 1-bit delta-sigma stream back into
// signed 16-bit PCM words held in a valid/rd handshake register.
module deltasigma_decoder #(
   parameter int DECIM_LOG2 = 7,
   parameter int ACC_W      = 2*DECIM_LOG2+3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               bs,
   input  logic               sample,
   input  logic               rd,
   output logic signed [15:0] d,
   output logic               valid,
   output logic               overrun
);

   localparam int SHIFT = 15 - 2*DECIM_LOG2;
   localparam int SW    = ACC_W + 16;
   localparam logic signed [SW-1:0] S_MAX = SW'(32767);
   localparam logic signed [SW-1:0] S_MIN = SW'(-32768);

   // Left-align the comb output to 16 bits; only a full-scale run can exceed range.
   function automatic logic signed [15:0] scale_sat(input logic signed [ACC_W-1:0] yin);
      logic signed [SW-1:0] s;
      s = SW'(yin) <<< SHIFT;
      if (s > S_MAX)
         scale_sat = 16'sh7FFF;
      else if (s < S_MIN)
         scale_sat = 16'sh8000;
      else
         scale_sat = s[15:0];
   endfunction

   logic signed [ACC_W-1:0] x;
   logic signed [ACC_W-1:0] i1, i2, i1_nxt, i2_nxt;
   logic [DECIM_LOG2-1:0]   cnt;
   logic signed [ACC_W-1:0] tap_p0, tap_d1, c1_d1, c1, y;
   logic                    vld_p0, vld_p1, first;
   logic signed [15:0]      word_p1;

   always_comb begin
      x      = bs ? ACC_W'(1) : {ACC_W{1'b1}};
      i1_nxt = i1 + x;
      i2_nxt = i2 + i1_nxt;
      c1     = tap_p0 - tap_d1;
      y      = c1 - c1_d1;
   end

   // Stage p0: integrators and framing, wrapping arithmetic by design
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i1     <= '0;
         i2     <= '0;
         cnt    <= '0;
         tap_p0 <= '0;
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= 1'b0;
         if (sample) begin
            i1  <= i1_nxt;
            i2  <= i2_nxt;
            cnt <= cnt + DECIM_LOG2'(1);
            if (cnt == '1) begin
               tap_p0 <= i2_nxt;
               vld_p0 <= 1'b1;
            end
         end
      end
   end

   // Stage p1: combs; the first frame after reset only primes the history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tap_d1  <= '0;
         c1_d1   <= '0;
         word_p1 <= '0;
         vld_p1  <= 1'b0;
         first   <= 1'b1;
      end else begin
         vld_p1 <= 1'b0;
         if (vld_p0) begin
            tap_d1  <= tap_p0;
            c1_d1   <= c1;
            word_p1 <= scale_sat(y);
            vld_p1  <= ~first;
            first   <= 1'b0;
         end
      end
   end

   // Stage p2: holding register and handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d       <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else if (vld_p1) begin
         d     <= word_p1;
         valid <= 1'b1;
         if (valid && !rd)
            overrun <= 1'b1;
      end else if (rd && valid) begin
         valid   <= 1'b0;
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_deltasigma_decoder.sv
// Bench for deltasigma_decoder: directed and random bit streams scored against
// a triangular-window (sinc2) reference computed from the sample history.
module tb_deltasigma_decoder;

   localparam int L = 7;
   localparam int R = 1 << L;

   logic               clk = 1'b0;
   logic               reset, bs, sample, rd;
   logic signed [15:0] d;
   logic               valid, overrun;

   int n_assert = 0;
   int n_fail   = 0;

   deltasigma_decoder #(.DECIM_LOG2(L)) dut (
      .clk(clk), .reset(reset), .bs(bs), .sample(sample), .rd(rd),
      .d(d), .valid(valid), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Reference model state
   int   hist[$];
   int   nsamp;
   logic ldv[2];
   int   ldw[2];
   int   exp_d;
   logic exp_valid, exp_ovr;
   int   pidx, enc_acc, enc_in;
   int   first_v;

   // Output word = triangular-weighted sum of the last 2R symbols, scaled and clamped
   function automatic int sinc2_word();
      int acc = 0;
      int s;
      for (int i = 0; i < 2*R; i++) begin
         int h;
         h = (i < R) ? i + 1 : 2*R - 1 - i;
         acc += h * hist[hist.size()-1-i];
      end
      s = acc * (1 << (15 - 2*L));
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      return s;
   endfunction

   function automatic logic gen_bs(input int mode);
      logic b;
      case (mode)
         0: b = 1'b1;
         1: b = 1'b0;
         2: b = (pidx % 2 == 0);
         3: b = (pidx % 4 != 3);
         4: b = 1'($urandom);
         default: begin
            enc_acc += enc_in + 32768;
            b = (enc_acc >= 65536);
            enc_acc = enc_acc % 65536;
         end
      endcase
      pidx++;
      return b;
   endfunction

   task automatic chk(input string tag, input int obs, input int expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      nsamp = 0;
      ldv[0] = 1'b0; ldv[1] = 1'b0; ldw[0] = 0; ldw[1] = 0;
      exp_d = 0; exp_valid = 1'b0; exp_ovr = 1'b0;
      pidx = 0; enc_acc = 0;
   endtask

   task automatic step(input logic b, input logic s, input logic r);
      logic nv;
      int   nw;
      bs = b; sample = s; rd = r;
      @(posedge clk);
      nv = 1'b0;
      nw = 0;
      if (s) begin
         hist.push_back(b ? 1 : -1);
         if (hist.size() > 2*R) void'(hist.pop_front());
         nsamp++;
         if (nsamp % R == 0 && nsamp >= 2*R) begin
            nv = 1'b1;
            nw = sinc2_word();
         end
      end
      if (ldv[1]) begin
         if (exp_valid && !r) exp_ovr = 1'b1;
         exp_valid = 1'b1;
         exp_d = ldw[1];
      end else if (r && exp_valid) begin
         exp_valid = 1'b0;
         exp_ovr = 1'b0;
      end
      ldv[1] = ldv[0]; ldw[1] = ldw[0];
      ldv[0] = nv;     ldw[0] = nw;
      #1;
      chk("d", int'(d), exp_d);
      chk("valid", int'(valid), int'(exp_valid));
      chk("overrun", int'(overrun), int'(exp_ovr));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      model_reset();
      chk("rst_d", int'(d), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_overrun", int'(overrun), 0);
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // rdmode: 0 never read, 1 read whenever valid, 2 random reads; every=0 gives random strobes
   task automatic run(input int ncyc, input int mode, input int every, input int rdmode);
      for (int c = 0; c < ncyc; c++) begin
         logic s, b, r;
         s = (every == 0) ? 1'($urandom) : (c % every == every - 1);
         b = s ? gen_bs(mode) : 1'($urandom);
         case (rdmode)
            0:       r = 1'b0;
            1:       r = valid;
            default: r = ($urandom_range(0, 7) == 0);
         endcase
         step(b, s, r);
      end
   endtask

   task automatic run_to_load();
      int g = 0;
      while (!ldv[1] && g < 4*R) begin
         step(gen_bs(0), 1'b1, 1'b0);
         g++;
      end
      chk("load_wait", int'(g < 4*R), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; bs = 1'b0; sample = 1'b0; rd = 1'b0;
      #1;

      // All ones, strobe every clk: first word at 2R+2 clks, saturated positive
      do_reset();
      first_v = -1;
      for (int c = 1; c <= 300; c++) begin
         step(gen_bs(0), 1'b1, 1'b0);
         if (valid && first_v < 0) first_v = c;
      end
      chk("t1_latency", first_v, 2*R + 2);
      chk("t1_word", int'(d), 32767);
      run(4*R, 0, 1, 1);
      chk("t1_steady", int'(d), 32767);

      // All zeros, read after every word
      do_reset();
      run(4*R, 1, 1, 1);
      chk("t2_word", int'(d), -32768);
      chk("t2_overrun", int'(overrun), 0);

      // Alternating and 1110 patterns
      do_reset();
      run(3*R, 2, 1, 1);
      chk("t3_alt", int'(d), 0);
      do_reset();
      run(4*R + 4, 3, 1, 1);
      chk("t3_1110", int'(d), 16384);

      // Handshake: overrun, read clears, read on the load clock
      do_reset();
      run(5*R + 4, 0, 1, 0);
      chk("t4_valid", int'(valid), 1);
      chk("t4_overrun", int'(overrun), 1);
      step(1'b1, 1'b0, 1'b1);
      chk("t4_rd_valid", int'(valid), 0);
      chk("t4_rd_overrun", int'(overrun), 0);
      run_to_load();
      step(gen_bs(0), 1'b1, 1'b0);
      chk("t4_load_valid", int'(valid), 1);
      run_to_load();
      step(gen_bs(0), 1'b1, 1'b1);
      chk("t4_rdload_valid", int'(valid), 1);
      chk("t4_rdload_overrun", int'(overrun), 0);
      run_to_load();
      step(gen_bs(0), 1'b1, 1'b0);
      chk("t4_ovr_again", int'(overrun), 1);
      run_to_load();
      step(gen_bs(0), 1'b1, 1'b1);
      chk("t4_rdload_keep_valid", int'(valid), 1);
      chk("t4_rdload_keep_overrun", int'(overrun), 1);

      // Sparse strobes, reset at sample 60 of a frame, then restart framing
      do_reset();
      run(4*(2*R + 60), 0, 4, 0);
      chk("t5_pre_valid", int'(valid), 1);
      do_reset();
      first_v = -1;
      for (int c = 0; c < 8*R + 40; c++) begin
         logic s;
         s = (c % 4 == 3);
         step(s ? gen_bs(0) : 1'b0, s, 1'b0);
         if (valid && first_v < 0) first_v = nsamp;
      end
      chk("t5_samples", first_v, 2*R);
      chk("t5_word", int'(d), 32767);

      // Random stream, random strobes and reads
      do_reset();
      run(3000, 4, 0, 2);

      // Loopback from a first-order delta-sigma encoder
      do_reset();
      enc_in = 16384;
      run(6*R, 5, 1, 1);
      chk("t7_half", int'(int'(d) >= 16384 - 512 && int'(d) <= 16384 + 512), 1);
      enc_in = 0;
      run(4*R, 5, 1, 1);
      chk("t7_zero", int'(int'(d) >= -512 && int'(d) <= 512), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/deltasigma_decoder.md
Name: deltasigma_decoder

Overview:
- Receive-side counterpart of the first-order delta-sigma DAC modulator.
- Accepts a 1-bit delta-sigma bit stream, qualified by a sample-rate strobe, and converts it back to signed 16-bit PCM words.
- Uses a second-order CIC (sinc2) decimator.
- Presents each word in a holding register with a valid/read handshake.
- Used for loopback test of the DAC path and as a bit-stream ADC front-end.

Parameters:
- DECIM_LOG2, 7, log2 of the decimation ratio R. R = 128 bit-stream samples per output word. Legal range 4..7.
- ACC_W, 2*DECIM_LOG2+3, internal integrator/comb width in bits. Arithmetic is modular and wraps.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- bs  input  1  bit stream in; 1 = +1, 0 = -1
- sample  input  1  one-clk strobe; bs is valid and consumed on this cycle
- rd  input  1  one-clk read strobe from the consumer
- d  output  16  decoded PCM word, two's complement
- valid  output  1  d holds an unread word
- overrun  output  1  sticky flag: an unread word was overwritten

Behaviour:
- Reset (reset=0, async): integrators, combs, frame counter and d are cleared to 0. valid=0, overrun=0, first-frame flag=1.
- Input mapping: x = +1 when bs=1, x = -1 when bs=0. x is sign-extended to ACC_W.
- Integrators update only on clk edges with sample=1: i1 <= i1 + x; i2 <= i2 + i1_new. With sample=0 all state holds.
- Frame counter: DECIM_LOG2 bits, increments on each sample, wraps R-1 -> 0.
- Decimate event occurs on the sample edge where the counter = R-1:
  - capture i2_new into the tap register;
  - set the dec_pend pulse.
- Comb stage, on the clk after dec_pend: c1 = tap - tap_d1; y = c1 - c1_d1; tap_d1 <= tap; c1_d1 <= c1.
- Scaling:
  - y range is -R^2..+R^2.
  - Compute s = y << (15 - 2*DECIM_LOG2).
  - Saturate: s >= 32768 gives 0x7FFF; s < -32768 gives 0x8000.
  - Rounding is not applied.
- Output load happens on the clk after the comb stage, so d updates 2 clks after the R-th sample edge.
- First-frame suppression:
  - The first decimate event after reset updates the comb history only. d, valid and overrun are unchanged, and the first-frame flag clears.
  - The first valid word therefore appears after 2R samples.
- Handshake:
  - Word load with valid=0: d <= word, valid <= 1.
  - Word load with valid=1 and rd=0: d <= word, valid stays 1, overrun <= 1.
  - Word load with rd=1 on the same clk: d <= word, valid stays 1, overrun unchanged.
  - rd=1 with no load: valid <= 0, overrun <= 0.
  - rd while valid=0 has no effect.
- A sample strobe that arrives during the comb/load pipeline is processed normally. The pipeline is independent of the integrators, so back-to-back sample strobes (sample=1 every clk) are legal.
- Reset asserted mid-frame:
  - All state clears immediately, including the partial frame.
  - After release, framing restarts at count 0 and first-frame suppression applies again.
- Wrap-around: integrator overflow is intentional and cancels in the combs. Saturating logic is forbidden anywhere except the final scaling step.

Test Plan:
- Reset, then bs=1 on every sample (sample=1 every clk) -> valid rises 2 clks after the 256th sample edge; d=0x7FFF (y=16384 saturated). A new word arrives every 128 samples.
- bs=0 constant -> d=0x8000 for every word; overrun stays 0 when rd is pulsed after each valid.
- bs pattern 1,0,1,0,... -> d=0x0000. Pattern 1,1,1,0 repeated -> d=0x4000 (y=8192).
- Never pulse rd across 3 word periods -> valid=1, overrun=1 after the 2nd loaded word. Pulse rd -> valid=0, overrun=0. Also pulse rd on the exact load clk -> valid stays 1, overrun unchanged.
- Sample strobe every 4th clk with constant bs=1, then assert reset for 1 clk at sample 60 of a frame -> outputs clear immediately. Next valid appears only after 256 further samples; d=0x7FFF.
- Loopback from the delta-sigma encoder (its bs/sample into this block), encoder fed d=0x4000 continuously -> steady-state decoded d is within 0x4000 ± 0x0200. Encoder fed 0x0000 -> decoded d is within ± 0x0200.
